lz_normalizer: RTL

//  Pipelined normaliser that consumes the leading-zero count of a word and left-justifies it.

---
 rtl/lz_pkg.sv | 22 ++
 rtl/lz_count.sv | 21 ++
 rtl/lz_normalizer.sv | 110 +++++++++++
 3 files changed

// File: rtl/lz_pkg.sv
// Shared constants and result bundle for the
// leading-zero normaliser pipeline.
package lz_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_EXP_WIDTH  = 8;

  function automatic int clog2w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEF_ZERO_WIDTH = clog2w(DEF_DATA_WIDTH);

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_EXP_WIDTH-1:0]  exp;
    logic [DEF_ZERO_WIDTH-1:0] lz;
    logic                      zero;
    logic                      uflow;
  } lz_result_t;

endpackage

// File: rtl/lz_count.sv
// MSB-first leading-zero counter; an all-zero
// word reports DATA_WIDTH.
module lz_count
  import lz_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ZERO_WIDTH = clog2w(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [ZERO_WIDTH-1:0] lz
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    lz = ZERO_WIDTH'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (data[i]) lz = ZERO_WIDTH'(DATA_WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/lz_normalizer.sv
// Two-stage normaliser: count/compare, then
// barrel shift and exponent adjust.
module lz_normalizer
  import lz_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ZERO_WIDTH = clog2w(DATA_WIDTH),
  parameter int EXP_WIDTH  = DEF_EXP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [EXP_WIDTH-1:0]  in_exp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic [ZERO_WIDTH-1:0] out_lz,
  output logic                  out_zero,
  output logic                  out_uflow
);

  localparam int CW =
    (ZERO_WIDTH > EXP_WIDTH) ? ZERO_WIDTH : EXP_WIDTH;

  logic                  v1, v2;
  logic                  s1_rdy, s2_rdy;
  logic [ZERO_WIDTH-1:0] lz;
  logic                  zero_in, uflow_in;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [EXP_WIDTH-1:0]  s1_exp;
  logic [ZERO_WIDTH-1:0] s1_lz;
  logic                  s1_zero, s1_uflow;
  logic [ZERO_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] n_data;
  logic [EXP_WIDTH-1:0]  n_exp;

  lz_count #(
    .DATA_WIDTH(DATA_WIDTH),
    .ZERO_WIDTH(ZERO_WIDTH)
  ) u_cnt (
    .data(in_data),
    .lz  (lz)
  );

  assign s2_rdy    = !v2 || out_ready;
  assign s1_rdy    = !v1 || s2_rdy;
  assign in_ready  = s1_rdy && !rst;
  assign out_valid = v2;

  // Zero words never flag underflow; they clamp to exp 0.
  always_comb begin
    zero_in  = (lz == ZERO_WIDTH'(DATA_WIDTH));
    uflow_in = !zero_in && (CW'(lz) > CW'(in_exp));
  end

  // Stage 1: capture word, count and underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      s1_data  <= '0;
      s1_exp   <= '0;
      s1_lz    <= '0;
      s1_zero  <= 1'b0;
      s1_uflow <= 1'b0;
    end else if (s1_rdy) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_data  <= in_data;
        s1_exp   <= in_exp;
        s1_lz    <= lz;
        s1_zero  <= zero_in;
        s1_uflow <= uflow_in;
      end
    end
  end

  // Clamped shift amount fits the count width:
  // when clamping, exp < lz <= DATA_WIDTH.
  always_comb begin
    shift  = s1_uflow ? ZERO_WIDTH'(s1_exp) : s1_lz;
    n_data = s1_data << shift;
    n_exp  = s1_zero ? '0
                     : s1_exp - EXP_WIDTH'(shift);
  end

  // Stage 2: result register, held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      out_data  <= '0;
      out_exp   <= '0;
      out_lz    <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else if (s2_rdy) begin
      v2 <= v1;
      if (v1) begin
        out_data  <= n_data;
        out_exp   <= n_exp;
        out_lz    <= s1_lz;
        out_zero  <= s1_zero;
        out_uflow <= s1_uflow;
      end
    end
  end

endmodule
